// File: rtl/multi_channel_clock_generator.sv
// multi_channel_clock_generator: NUM_CHANNELS divided clocks from clk_in, each with its own high, low and offset lengths.
// New settings are held in shared pending registers until each channel reaches a period boundary.
module multi_channel_clock_generator #(
  parameter int CYCLE_WIDTH  = 16,
  parameter int NUM_CHANNELS = 4
) (
  input  logic                                clk_in,
  input  logic                                rst,
  input  logic                                enable,
  input  logic [NUM_CHANNELS*CYCLE_WIDTH-1:0] high_phase_cycles,
  input  logic [NUM_CHANNELS*CYCLE_WIDTH-1:0] low_phase_cycles,
  input  logic [NUM_CHANNELS*CYCLE_WIDTH-1:0] phase_offset_cycles,
  input  logic                                cfg_update,
  output logic [NUM_CHANNELS-1:0]             clk_out,
  output logic [NUM_CHANNELS-1:0]             rise_pulse,
  output logic                                busy,
  output logic                                cfg_pending
);
  localparam int W  = CYCLE_WIDTH;
  localparam int BW = NUM_CHANNELS * CYCLE_WIDTH;
  typedef enum logic [1:0] {IDLE, OFFSET, HIGH, LOW} state_t;
  logic [BW-1:0] pend_h_q, pend_h_d, pend_l_q, pend_l_d, pend_o_q, pend_o_d;
  logic [NUM_CHANNELS-1:0] pend_bit, idle;
  function automatic logic [W-1:0] nz(input logic [W-1:0] v);
    return (v == '0) ? W'(1) : v;
  endfunction
  always_comb begin
    pend_h_d = cfg_update ? high_phase_cycles : pend_h_q;
    pend_l_d = cfg_update ? low_phase_cycles : pend_l_q;
    pend_o_d = cfg_update ? phase_offset_cycles : pend_o_q;
  end
  always_ff @(posedge clk_in) begin
    if (rst) begin
      pend_h_q <= '0;
      pend_l_q <= '0;
      pend_o_q <= '0;
    end else begin
      pend_h_q <= pend_h_d;
      pend_l_q <= pend_l_d;
      pend_o_q <= pend_o_d;
    end
  end
  assign busy        = ~&idle;
  assign cfg_pending = |pend_bit;
  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    state_t state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d, dec, act_h_q, act_h_d, act_l_q, act_l_d, act_o_q, act_o_d;
    logic pend_q, pend_d, clk_q, clk_d, last, apply, upd;
    always_ff @(posedge clk_in) begin
      if (rst) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        act_h_q <= '0;
        act_l_q <= '0;
        act_o_q <= '0;
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        act_h_q <= act_h_d;
        act_l_q <= act_l_d;
        act_o_q <= act_o_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
      end
    end
    // IDLE and the last LOW cycle are period boundaries; a same-edge strobe beats older pending values.
    always_comb begin
      last    = cnt_q == W'(1);
      dec     = cnt_q - W'(1);
      apply   = state_q == IDLE || (state_q == LOW && last);
      upd     = apply && (cfg_update || pend_q);
      act_h_d = upd ? (cfg_update ? high_phase_cycles[c*W +: W] : pend_h_q[c*W +: W]) : act_h_q;
      act_l_d = upd ? (cfg_update ? low_phase_cycles[c*W +: W] : pend_l_q[c*W +: W]) : act_l_q;
      act_o_d = upd ? (cfg_update ? phase_offset_cycles[c*W +: W] : pend_o_q[c*W +: W]) : act_o_q;
      pend_d  = !apply && (cfg_update || pend_q);
    end
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        IDLE: begin
          state_d = !enable ? IDLE : (act_o_d == '0) ? HIGH : OFFSET;
          cnt_d   = !enable ? '0 : (act_o_d == '0) ? nz(act_h_d) : act_o_d;
        end
        OFFSET: begin
          state_d = !enable ? IDLE : last ? HIGH : OFFSET;
          cnt_d   = !enable ? '0 : last ? nz(act_h_q) : dec;
        end
        HIGH: begin
          state_d = last ? LOW : HIGH;
          cnt_d   = last ? nz(act_l_q) : dec;
        end
        LOW: begin
          state_d = !last ? LOW : enable ? HIGH : IDLE;
          cnt_d   = !last ? dec : enable ? nz(act_h_d) : '0;
        end
        default: ;
      endcase
    end
    always_comb clk_d = state_d == HIGH;
    assign clk_out[c]    = clk_q;
    assign rise_pulse[c] = state_q == HIGH && cnt_q == nz(act_h_q);
    assign idle[c]       = state_q == IDLE;
    assign pend_bit[c]   = pend_q;
  end
endmodule

// File: tb/tb_multi_channel_clock_generator.sv
// tb_multi_channel_clock_generator: directed cycle-by-cycle vectors for the four-channel clock generator.
module tb_multi_channel_clock_generator;
  localparam int W = 16;
  localparam int N = 4;
  localparam int BW = N * W;
  logic clk_in = 1'b0, rst = 1'b1, enable = 1'b0, cfg_update = 1'b0;
  logic [BW-1:0] high_phase_cycles = '0, low_phase_cycles = '0, phase_offset_cycles = '0;
  logic [N-1:0] clk_out, rise_pulse;
  logic busy, cfg_pending;
  int checks = 0, errors = 0;
  typedef struct {
    logic r, en, upd;
    logic [BW-1:0] h, l, o;
    logic [N-1:0] ec, er;
    logic eb, ep;
  } vec_t;
  vec_t tbl[$];

  multi_channel_clock_generator #(.CYCLE_WIDTH(W), .NUM_CHANNELS(N)) dut (
    .clk_in(clk_in), .rst(rst), .enable(enable),
    .high_phase_cycles(high_phase_cycles), .low_phase_cycles(low_phase_cycles),
    .phase_offset_cycles(phase_offset_cycles), .cfg_update(cfg_update),
    .clk_out(clk_out), .rise_pulse(rise_pulse), .busy(busy), .cfg_pending(cfg_pending)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [BW-1:0] rep(input int v);
    return {N{v[W-1:0]}};
  endfunction

  task automatic check(input string name, input int idx, input logic [N-1:0] act, input logic [N-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %b expected %b", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic [N-1:0] ec, input logic [N-1:0] er, input logic eb, input logic ep);
    check("clk_out", idx, clk_out, ec);
    check("rise_pulse", idx, rise_pulse, er);
    check("busy", idx, N'(busy), N'(eb));
    check("cfg_pending", idx, N'(cfg_pending), N'(ep));
  endtask

  task automatic add(input logic r, input logic en, input logic upd, input logic [BW-1:0] h, input logic [BW-1:0] l,
                     input logic [BW-1:0] o, input logic [N-1:0] ec, input logic [N-1:0] er, input logic eb, input logic ep);
    tbl.push_back('{r, en, upd, h, l, o, ec, er, eb, ep});
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    logic [BW-1:0] z, h, l, o;
    z = '0;
    add(1, 0, 0, z, z, z, 4'b0000, 4'b0000, 0, 0);
    add(1, 0, 0, z, z, z, 4'b0000, 4'b0000, 0, 0);
    // ch0 H=2 L=3, other channels all-zero config (period 2)
    h = BW'(2); l = BW'(3);
    add(0, 0, 1, h, l, z, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 1, 0, h, l, z, 4'b0001, 4'b0000, 1, 0);
    add(0, 1, 0, h, l, z, 4'b1110, 4'b1110, 1, 0);
    add(0, 1, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 1, 0, h, l, z, 4'b1110, 4'b1110, 1, 0);
    add(0, 1, 0, h, l, z, 4'b0001, 4'b0001, 1, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1110, 1, 0);
    add(0, 1, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 1, 0, h, l, z, 4'b1110, 4'b1110, 1, 0);
    add(0, 1, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0001, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 0, 0);
    // H=L=1, offsets 0..3: staggered first rises
    o = {16'd3, 16'd2, 16'd1, 16'd0};
    add(0, 0, 1, z, z, o, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, z, z, o, 4'b0001, 4'b0001, 1, 0);
    add(0, 1, 0, z, z, o, 4'b0010, 4'b0010, 1, 0);
    add(0, 1, 0, z, z, o, 4'b0101, 4'b0101, 1, 0);
    add(0, 1, 0, z, z, o, 4'b1010, 4'b1010, 1, 0);
    add(0, 1, 0, z, z, o, 4'b0101, 4'b0101, 1, 0);
    add(0, 1, 0, z, z, o, 4'b1010, 4'b1010, 1, 0);
    add(0, 0, 0, z, z, o, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, z, z, o, 4'b0000, 4'b0000, 0, 0);
    // H=3 L=2, enable dropped in first high cycle
    h = rep(3); l = rep(2);
    add(0, 0, 1, h, l, z, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 0, 0, h, l, z, 4'b1111, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b1111, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 0, 0);
    // enable dropped during OFFSET
    h = rep(1); l = rep(1); o = rep(2);
    add(0, 0, 1, h, l, o, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, h, l, o, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, o, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 0, h, l, o, 4'b0000, 4'b0000, 0, 0);
    // zero config, one-cycle enable drop while HIGH keeps the clock running
    add(0, 0, 1, z, z, z, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, z, z, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 0, 0, z, z, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 1, 0, z, z, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 1, 0, z, z, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 1, 0, z, z, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 0, 0, z, z, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, z, z, z, 4'b0000, 4'b0000, 0, 0);
    // H=L=4 running, update to 1/1 in second high cycle
    h = rep(4); l = rep(4);
    add(0, 0, 1, h, l, z, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b0000, 1, 0);
    h = rep(1); l = rep(1);
    add(0, 1, 1, h, l, z, 4'b1111, 4'b0000, 1, 1);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b0000, 1, 1);
    for (int i = 0; i < 4; i++) add(0, 1, 0, h, l, z, 4'b0000, 4'b0000, 1, 1);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 1, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 0, 0);
    // reset mid-HIGH with a pending update, then restart on cleared config
    h = rep(3); l = rep(3);
    add(0, 0, 1, h, l, z, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 1, 1, rep(5), l, z, 4'b1111, 4'b0000, 1, 1);
    add(1, 1, 0, h, l, z, 4'b0000, 4'b0000, 0, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 0, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 1, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 1, 0, h, l, z, 4'b1111, 4'b1111, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 1, 0);
    add(0, 0, 0, h, l, z, 4'b0000, 4'b0000, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      rst = tbl[i].r;
      enable = tbl[i].en;
      cfg_update = tbl[i].upd;
      high_phase_cycles = tbl[i].h;
      low_phase_cycles = tbl[i].l;
      phase_offset_cycles = tbl[i].o;
      tick();
      check_all(i, tbl[i].ec, tbl[i].er, tbl[i].eb, tbl[i].ep);
    end

    // simultaneous cfg_update and start from IDLE: the start uses the new O=2, H=2
    rst = 0; enable = 1; cfg_update = 1;
    high_phase_cycles = rep(2); low_phase_cycles = rep(1); phase_offset_cycles = rep(2);
    tick(); check_all(1000, 4'b0000, 4'b0000, 1, 0);
    cfg_update = 0;
    tick(); check_all(1001, 4'b0000, 4'b0000, 1, 0);
    tick(); check_all(1002, 4'b1111, 4'b1111, 1, 0);
    enable = 0;
    tick(); check_all(1003, 4'b1111, 4'b0000, 1, 0);
    tick(); check_all(1004, 4'b0000, 4'b0000, 1, 0);
    for (int i = 0; i < 10 && busy; i++) tick();
    check("busy_fall", 1005, N'(busy), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
